// File: rtl/freq_sort.sv
// freq_sort: streams the nonzero entries of a 128-bin histogram as leaves in
// ascending frequency order (ties: lower symbol index first), one linear
// 128-cycle scan pass per leaf.
// Optional feature: define FREQ_SORT_LEAF_CNT_EN to add the leaf_cnt output.
// Latency: sym_valid rises on the 128th edge after the capture or handshake edge
// (cycle 129 when the capture cycle is counted as cycle 1).
module freq_sort (
    input  logic              clk,
    input  logic              reset,
    input  logic [127:0][15:0] curr_count,
    input  logic              finish_cnt,
    output logic [6:0]        sym_out,
    output logic [15:0]       freq_out,
    output logic              sym_valid,
    input  logic              sym_ready,
    output logic              busy,
    output logic              sort_done
`ifdef FREQ_SORT_LEAF_CNT_EN
    ,
    output logic [7:0]        leaf_cnt
`endif
);

    localparam int unsigned N_SYM  = 128;
    localparam int unsigned SYM_W  = 7;
    localparam int unsigned FREQ_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [FREQ_W-1:0] snap [N_SYM];
    logic [N_SYM-1:0]  emitted;
    logic [SYM_W-1:0]  idx;
    logic              cand_valid;
    logic [SYM_W-1:0]  cand_sym;
    logic [FREQ_W-1:0] cand_freq;

    logic [FREQ_W-1:0] entry;
    logic              take;
    logic              fin_valid;
    logic [SYM_W-1:0]  fin_sym;
    logic [FREQ_W-1:0] fin_freq;
    logic              capture;
    logic              handshake;
    logic              last;

    // Scan comparator: candidate including the entry examined this cycle
    always_comb begin
        entry     = snap[idx];
        take      = (state == SCAN) && (entry != '0) && !emitted[idx] &&
                    (!cand_valid || (entry < cand_freq));
        fin_valid = cand_valid | take;
        fin_sym   = take ? idx : cand_sym;
        fin_freq  = take ? entry : cand_freq;
        capture   = (state == IDLE) && finish_cnt;
        handshake = (state == EMIT) && sym_valid && sym_ready;
        last      = (idx == SYM_W'(N_SYM - 1));
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (finish_cnt) state_next = SCAN;
            SCAN: if (last) state_next = fin_valid ? EMIT : DONE;
            EMIT: if (sym_ready) state_next = SCAN;
            DONE: if (!finish_cnt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Snapshot, scan bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_SYM; i++) snap[i] <= '0;
            emitted    <= '0;
            idx        <= '0;
            cand_valid <= 1'b0;
            cand_sym   <= '0;
            cand_freq  <= '0;
            sym_out    <= '0;
            freq_out   <= '0;
            sym_valid  <= 1'b0;
            busy       <= 1'b0;
            sort_done  <= 1'b0;
        end else begin
            if (capture) begin
                for (int i = 0; i < N_SYM; i++) snap[i] <= curr_count[i];
                emitted    <= '0;
                idx        <= '0;
                cand_valid <= 1'b0;
            end
            if (state == SCAN) begin
                idx <= idx + SYM_W'(1);
                if (take) begin
                    cand_valid <= 1'b1;
                    cand_sym   <= idx;
                    cand_freq  <= entry;
                end
                if (last && fin_valid) begin
                    sym_out  <= fin_sym;
                    freq_out <= fin_freq;
                end
            end
            if (handshake) begin
                emitted[cand_sym] <= 1'b1;
                cand_valid        <= 1'b0;
                idx               <= '0;
            end
            sym_valid <= (state_next == EMIT);
            busy      <= (state_next == SCAN) || (state_next == EMIT);
            sort_done <= (state_next == DONE);
        end
    end

`ifdef FREQ_SORT_LEAF_CNT_EN
    // Handshakes since the last capture
    always_ff @(posedge clk) begin
        if (!reset)         leaf_cnt <= '0;
        else if (capture)   leaf_cnt <= '0;
        else if (handshake) leaf_cnt <= leaf_cnt + 8'd1;
    end
`endif

endmodule
